// File: rtl/vga_fb_scaler.sv
// VGA timing generator with a double-buffered RRRGGGBB framebuffer, scanned with 2^SCALE_LOG2 pixel replication.
// Optional macro TEST_PATTERN_EN adds pattern_sel, which replaces framebuffer pixels with 8 vertical colour bars.
module vga_fb_scaler #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SCALE_LOG2 = 2,
    parameter bit SYNC_POL   = 1'b0,
    localparam int FB_W      = H_VISIBLE >> SCALE_LOG2,
    localparam int FB_H      = V_VISIBLE >> SCALE_LOG2,
    localparam int FB_SIZE   = FB_W * FB_H,
    localparam int AW        = $clog2(FB_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_oob,
    input  logic          swap_req,
    output logic          swap_ack,
`ifdef TEST_PATTERN_EN
    input  logic          pattern_sel,
`endif
    output logic          frame_start,
    output logic [9:0]    hc_out,
    output logic [9:0]    vc_out,
    output logic          hsync,
    output logic          vsync,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]    hc, vc;
    logic          front_sel, pending, swap, frame_end, wr_in_range;
    logic          active0, hs0, vs0;
    logic [AW-1:0] rd_addr;
    logic [7:0]    bank0 [FB_SIZE];
    logic [7:0]    bank1 [FB_SIZE];
    logic [7:0]    rd_q, pix;
    logic          act_d1, hs_d1, vs_d1;

    assign hc_out      = hc;
    assign vc_out      = vc;
    assign frame_end   = (hc == H_LAST) && (vc == V_LAST);
    assign swap        = frame_end && (pending || swap_req) && !rst;
    assign swap_ack    = swap;
    assign wr_ready    = !swap;
    assign frame_start = (hc == '0) && (vc == '0) && !rst;
    assign wr_in_range = 32'(wr_addr) < FB_SIZE;

    assign active0 = (hc < H_VIS) && (vc < V_VIS);
    assign hs0     = (hc >= HS_BEG) && (hc < HS_END);
    assign vs0     = (vc >= VS_BEG) && (vc < VS_END);
    // Outside the visible area this wraps, but the read is gated by active0 anyway.
    assign rd_addr = AW'(((32'(vc) >> SCALE_LOG2) * FB_W) + (32'(hc) >> SCALE_LOG2));

    always_ff @(posedge clk) begin
        if (rst) begin
            hc        <= '0;
            vc        <= '0;
            front_sel <= 1'b0;
            pending   <= 1'b0;
            wr_oob    <= 1'b0;
        end else begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
            end else begin
                hc <= hc + 10'd1;
            end
            if (swap) begin
                front_sel <= ~front_sel;
                pending   <= 1'b0;
            end else if (swap_req) begin
                pending   <= 1'b1;
            end
            if (wr_valid && wr_ready && !wr_in_range)
                wr_oob <= 1'b1;
        end
    end

    // Writes target the back bank; wr_ready is low in the swap cycle, so front_sel is stable here.
    always_ff @(posedge clk) begin
        if (wr_valid && wr_ready && wr_in_range) begin
            if (front_sel) bank0[wr_addr] <= wr_data;
            else           bank1[wr_addr] <= wr_data;
        end
        if (active0)
            rd_q <= front_sel ? bank1[rd_addr] : bank0[rd_addr];
    end

`ifdef TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_VISIBLE / 8);
    logic [2:0] bar_d1;
    logic       pat_d1;

    always_ff @(posedge clk) begin
        bar_d1 <= 3'(hc / BAR_W);
        pat_d1 <= pattern_sel;
    end

    assign pix = pat_d1 ? {{3{bar_d1[2]}}, {3{bar_d1[1]}}, {2{bar_d1[0]}}} : rd_q;
`else
    assign pix = rd_q;
`endif

    // Sync/active ride alongside the RAM read so everything leaves two cycles after the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_d1 <= 1'b0;
            hs_d1  <= ~SYNC_POL;
            vs_d1  <= ~SYNC_POL;
            hsync  <= ~SYNC_POL;
            vsync  <= ~SYNC_POL;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else begin
            act_d1 <= active0;
            hs_d1  <= hs0 ? SYNC_POL : ~SYNC_POL;
            vs_d1  <= vs0 ? SYNC_POL : ~SYNC_POL;
            hsync  <= hs_d1;
            vsync  <= vs_d1;
            red    <= act_d1 ? {pix[7:5], pix[7]} : 4'h0;
            green  <= act_d1 ? {pix[4:2], pix[4]} : 4'h0;
            blue   <= act_d1 ? {pix[1:0], pix[1:0]} : 4'h0;
        end
    end

endmodule

// File: tb/tb_vga_fb_scaler.sv
// Bench for vga_fb_scaler on a reduced raster (48x18 total, 8x3 framebuffer) with a frame-level reference model.
module tb_vga_fb_scaler;

    localparam int HV = 32, HF = 4, HS = 8, HB = 4;
    localparam int VV = 12, VF = 2, VS = 2, VB = 2;
    localparam int SL = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FW = HV >> SL;
    localparam int FSZ = FW * (VV >> SL);
    localparam int AW = $clog2(FSZ);

    logic          clk = 1'b0;
    logic          rst, wr_valid, swap_req;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ready, wr_oob, swap_ack, frame_start, hsync, vsync;
    logic [9:0]    hc_out, vc_out;
    logic [3:0]    red, green, blue;
`ifdef TEST_PATTERN_EN
    logic          pattern_sel;
`endif

    always #5 clk = ~clk;

    vga_fb_scaler #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SCALE_LOG2(SL), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_oob(wr_oob), .swap_req(swap_req), .swap_ack(swap_ack),
`ifdef TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .frame_start(frame_start), .hc_out(hc_out), .vc_out(vc_out),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
    );

    typedef struct {
        bit       valid;
        bit       chk_col;
        bit       hs, vs;
        bit [3:0] r, g, b;
    } exp_t;

    int   total = 0, bad = 0, cyc = 0, acks = 0;
    int   mhc = 0, mvc = 0;
    bit   mfront = 0, mpend = 0, moob = 0, started = 0, last_ack = 0;
    bit [7:0] mem [2][FSZ];
    bit       known [2][FSZ];
    exp_t e_now = '{default: 0}, e_next = '{default: 0};

    function automatic exp_t idle_out();
        exp_t e;
        e = '{valid: 1, chk_col: 1, hs: 1, vs: 1, r: 0, g: 0, b: 0};
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d hc=%0d vc=%0d actual=%0h expected=%0h", name, cyc, mhc, mvc, act, exp);
        end
    endtask

    // One pixel-clock cycle: compare, record what this cycle's pixel must look like 2 cycles later, advance the model.
    task automatic step();
        bit       exp_ack, pat;
        exp_t     f;
        bit [7:0] px;
        int       a, k;
        #1;
        exp_ack = (mhc == HT-1) && (mvc == VT-1) && (mpend || swap_req) && !rst;
        if (started) begin
            chk("hc_out", int'(hc_out), mhc);
            chk("vc_out", int'(vc_out), mvc);
            chk("frame_start", int'(frame_start), int'(mhc == 0 && mvc == 0 && !rst));
            chk("swap_ack", int'(swap_ack), int'(exp_ack));
            chk("wr_ready", int'(wr_ready), int'(!exp_ack));
            chk("wr_oob", int'(wr_oob), int'(moob));
            if (e_now.valid) begin
                chk("hsync", int'(hsync), int'(e_now.hs));
                chk("vsync", int'(vsync), int'(e_now.vs));
                if (e_now.chk_col) begin
                    chk("red", int'(red), int'(e_now.r));
                    chk("green", int'(green), int'(e_now.g));
                    chk("blue", int'(blue), int'(e_now.b));
                end
            end
        end
        if (swap_ack) acks++;
        last_ack = exp_ack;

        pat = 0;
`ifdef TEST_PATTERN_EN
        pat = pattern_sel;
`endif
        f = idle_out();
        f.hs = !(mhc >= HV+HF && mhc < HV+HF+HS);
        f.vs = !(mvc >= VV+VF && mvc < VV+VF+VS);
        if (mhc < HV && mvc < VV) begin
            if (pat) begin
                k  = mhc / (HV/8);
                px = {{3{k[2]}}, {3{k[1]}}, {2{k[0]}}};
                f.chk_col = 1;
            end else begin
                a  = (mvc >> SL) * FW + (mhc >> SL);
                px = mem[mfront][a];
                f.chk_col = known[mfront][a];
            end
            f.r = {px[7:5], px[7]};
            f.g = {px[4:2], px[4]};
            f.b = {px[1:0], px[1:0]};
        end
        e_now  = e_next;
        e_next = f;

        if (rst) begin
            e_now = idle_out(); e_next = idle_out();
            mhc = 0; mvc = 0; mfront = 0; mpend = 0; moob = 0; acks = 0;
            started = 1;
        end else begin
            if (wr_valid && !exp_ack) begin
                if (int'(wr_addr) < FSZ) begin
                    mem[!mfront][int'(wr_addr)]   = wr_data;
                    known[!mfront][int'(wr_addr)] = 1;
                end else begin
                    moob = 1;
                end
            end
            if (exp_ack) begin mfront = !mfront; mpend = 0; end
            else if (swap_req) mpend = 1;
            if (mhc == HT-1) begin mhc = 0; mvc = (mvc == VT-1) ? 0 : mvc + 1; end
            else mhc++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_at(int h, int v);
        int n = 0;
        while (!(mhc == h && mvc == v)) begin
            step();
            n++;
            if (n > HT*VT + 2) begin
                total++; bad++;
                $display("FAIL wait_at target=(%0d,%0d) not reached actual=(%0d,%0d)", h, v, mhc, mvc);
                return;
            end
        end
    endtask

    initial begin
        int n;
        rst = 1; wr_valid = 0; swap_req = 0; wr_addr = '0; wr_data = '0;
`ifdef TEST_PATTERN_EN
        pattern_sel = 0;
`endif
        repeat (3) step();
        rst = 0;
        #1;
        chk("lit_first_frame_start", int'(frame_start), 1);
        chk("lit_first_hc", int'(hc_out), 0);

        // E0 at (0,0) of the back buffer, an out-of-range write, then three swap requests in one frame.
        wr_valid = 1; wr_addr = 5'd0; wr_data = 8'hE0; swap_req = 1; step();
        wr_addr = 5'd24; wr_data = 8'h55; swap_req = 0; step();
        wr_valid = 0;
        #1;
        chk("lit_oob_set", int'(wr_oob), 1);
        step();
        swap_req = 1; step(); swap_req = 0; repeat (5) step();
        swap_req = 1; step(); swap_req = 0;

        // Hold a write stream across the swap cycle; the held beat must be taken exactly once.
        wait_at(HT-3, VT-1);
        wr_valid = 1; n = 0;
        for (int i = 0; i < 4; i++) begin
            wr_addr = 5'(8 + n); wr_data = 8'(8'h21 * (n + 1));
            if (i == 2) begin
                #1;
                chk("lit_swap_ack", int'(swap_ack), 1);
                chk("lit_swap_ready_low", int'(wr_ready), 0);
            end
            step();
            if (!last_ack) n++;
        end
        wr_valid = 0;
        chk("lit_one_swap", acks, 1);

        wait_at(2, 0); #1;
        chk("lit_red_px00", int'(red), 4'hF);
        chk("lit_green_px00", int'(green), 0);
        chk("lit_blue_px00", int'(blue), 0);
        wait_at(5, 0); #1;
        chk("lit_red_px30", int'(red), 4'hF);
        wait_at(37, 0); #1;
        chk("lit_hsync_before", int'(hsync), 1);
        wait_at(38, 0); #1;
        chk("lit_hsync_start", int'(hsync), 0);
        wait_at(46, 0); #1;
        chk("lit_hsync_end", int'(hsync), 1);
        wait_at(2, 3); #1;
        chk("lit_red_px03", int'(red), 4'hF);
        wait_at(0, 16); #1;
        chk("lit_vsync_low", int'(vsync), 0);
        wait_at(2, 16); #1;
        chk("lit_vsync_end", int'(vsync), 1);
        chk("lit_oob_sticky", int'(wr_oob), 1);

        // Mid-frame reset.
        wait_at(10, 8);
        rst = 1; step(); rst = 0;
        #1;
        chk("lit_rst_hc", int'(hc_out), 0);
        chk("lit_rst_vc", int'(vc_out), 0);
        chk("lit_rst_frame_start", int'(frame_start), 1);
        chk("lit_rst_red", int'(red), 0);
        chk("lit_rst_hsync", int'(hsync), 1);
        chk("lit_rst_vsync", int'(vsync), 1);
        chk("lit_rst_oob", int'(wr_oob), 0);

        for (int i = 0; i < 26000; i++) begin
            rst      = ($urandom_range(0, 4999) == 0);
            wr_valid = rst ? 1'b0 : 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, 31));
            wr_data  = 8'($urandom);
            swap_req = ($urandom_range(0, 199) == 0);
`ifdef TEST_PATTERN_EN
            if (mhc == 0 && mvc == 0) pattern_sel = ($urandom_range(0, 3) == 0);
`endif
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
